spi_rr_arbiter: RTL and testbench
=================================

Name: spi_rr_arbiter

Overview:
- Shares one spi_master between NREQ requesters using round-robin arbitration.
- Per transaction: grants one requester, latches its tx byte, drives the master's start/data_in, and waits for the master's completion pulse.
- Returns the received byte to the granted requester only.
- Sits between client blocks (config loaders, sensor pollers) and the single spi_master/cs/sclk pin group.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PTR_W, 2, width of owner/pointer index; must equal clog2(NREQ).
- TIMEOUT_CYCLES, 64, clk cycles in XFER before abort (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester transaction request, level.
- tx_data  input  NREQ*8  per-requester tx byte; requester i occupies bits [8i+7:8i].
- gnt  output  NREQ  one-hot grant pulse, one cycle.
- rsp_valid  output  NREQ  one-hot response pulse, one cycle.
- rsp_data  output  8  received byte, valid while rsp_valid is nonzero.
- busy  output  1  high whenever state is not IDLE.
- timeout_err  output  1  one-cycle pulse on abort (tied 0 without macro).
- m_start  output  1  to spi_master start.
- m_data_in  output  8  to spi_master data_in.
- m_data_out  input  8  from spi_master data_out.
- m_done  input  1  one-cycle completion pulse from spi_master.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, ptr=0, owner=0.
  - gnt, rsp_valid, m_start, busy, timeout_err all 0.
  - rsp_data, m_data_in = 8'h00.
  - Applies from any state. Mid-XFER, m_start is low after that edge; any in-flight response is discarded.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If any req bit is set, select the first set bit searching from ptr upward, wrapping NREQ-1 -> 0.
  - At the same edge: owner <= winner, m_data_in <= tx_data[winner], gnt[winner] <= 1, state <= XFER.
  - No req set: stay in IDLE.
  - m_done in IDLE is ignored.
- XFER:
  - m_start held 1 for the whole state. gnt is 0 after the first XFER cycle.
  - On m_done=1: rsp_data <= m_data_out, m_start <= 0, state <= RESP.
  - req changes during XFER are ignored; tx_data is not re-sampled.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle.
  - ptr <= (owner+1) mod NREQ, with explicit wrap for non-power-of-2 NREQ.
  - state <= IDLE.
- Latency and throughput:
  - req seen in IDLE at edge N -> gnt high in cycle N+1, m_start high from N+1.
  - m_done at edge M -> rsp_valid high in cycle M+1.
  - Minimum transaction-to-transaction spacing: 1 IDLE cycle.
- Handshake rules:
  - Requester holds tx_data stable while req=1 and drops req in the cycle after gnt.
  - A req still high when IDLE is re-entered is treated as a new request.
- Simultaneous requests: resolved strictly by the rotating pointer, so no requester waits more than NREQ-1 transactions.
- Arithmetic: ptr/owner are PTR_W bits; timeout counter is clog2(TIMEOUT_CYCLES+1) bits and saturates.
- rsp_data holds its last value until the next capture.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined:
  - Counter clears on XFER entry and increments each XFER cycle.
  - If it reaches TIMEOUT_CYCLES without m_done: m_start <= 0, rsp_data <= 8'hFF, timeout_err pulses 1 cycle, state <= RESP, where rsp_valid[owner] pulses as normal.
  - If m_done and timeout land on the same edge, m_done wins and no error is flagged.
- SPI_ARB_TIMEOUT_EN undefined:
  - No counter; XFER waits indefinitely for m_done.
  - timeout_err constant 0.

Test Plan:
- Reset check: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, m_start=0, busy=0, rsp_data=8'h00; first grant after release goes to requester 0.
- Single request: req=4'b0100, tx_data[2]=8'hD5; model returns 8'hAA with m_done 9 cycles later -> gnt=4'b0100 next cycle, m_data_in=8'hD5, rsp_valid=4'b0100 with rsp_data=8'hAA one cycle after m_done.
- Round-robin fairness: hold req=4'b1111 over 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester skipped.
- Wrap and skip: after a grant to requester 3, req=4'b0101 -> next grant goes to 0, then 2.
- Reset mid-transfer: assert rst in the 3rd XFER cycle -> m_start=0 and busy=0 after that edge, no rsp_valid pulse, ptr=0.
- Timeout (macro on, TIMEOUT_CYCLES=64): m_done never asserted -> at the 64th XFER cycle m_start drops, timeout_err pulses, rsp_data=8'hFF, rsp_valid pulses for the owner; macro off -> busy remains 1 indefinitely.

Source files
------------

// File: rtl/spi_rr_arbiter.sv
// ============================================================================
// Module      : spi_rr_arbiter
// Description : Round-robin arbiter sharing one spi_master among NREQ clients.
//               Optional XFER watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rr_arbiter #(
    parameter int NREQ           = 4,
    parameter int PTR_W          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] tx_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              busy,
    output logic              timeout_err,
    output logic              m_start,
    output logic [7:0]        m_data_in,
    input  logic [7:0]        m_data_out,
    input  logic              m_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [NREQ-1:0] c_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    // Reject configurations the pointer arithmetic cannot represent.
    generate
        if (PTR_W != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("spi_rr_arbiter: illegal parameter combination");
        end
    endgenerate

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]   r_owner, w_owner_nxt;
    logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0]         r_rsp_data, w_rsp_data_nxt;
    logic               r_m_start, w_m_start_nxt;
    logic [7:0]         r_m_data_in, w_m_data_in_nxt;
    logic               r_timeout_err, w_timeout_err_nxt;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W:0]     w_sum;
    logic               w_timeout;

    // Rotating priority search: first set req at or above ptr, wrapping to 0.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end
            if (!w_found && req[w_sum[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[PTR_W-1:0];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int                c_TCNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_MAX = c_TCNT_W'(TIMEOUT_CYCLES);

    logic [c_TCNT_W-1:0] r_tcnt;
    logic [c_TCNT_W-1:0] w_tcnt_inc;

    assign w_tcnt_inc = (r_tcnt == c_TCNT_MAX) ? r_tcnt : r_tcnt + 1'b1;
    assign w_timeout  = (r_state == S_XFER) && (w_tcnt_inc == c_TCNT_MAX);

    // Counter is zero on XFER entry and counts XFER cycles, saturating.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_XFER) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= w_tcnt_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_owner_nxt       = r_owner;
        w_gnt_nxt         = '0;
        w_rsp_valid_nxt   = '0;
        w_rsp_data_nxt    = r_rsp_data;
        w_m_start_nxt     = r_m_start;
        w_m_data_in_nxt   = r_m_data_in;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_XFER;
                    w_owner_nxt     = w_winner;
                    w_m_data_in_nxt = tx_data[{w_winner, 3'b000} +: 8];
                    w_gnt_nxt       = c_ONE << w_winner;
                    w_m_start_nxt   = 1'b1;
                end
            end
            S_XFER: begin
                // Completion has priority over a coincident timeout.
                if (m_done) begin
                    w_rsp_data_nxt  = m_data_out;
                    w_m_start_nxt   = 1'b0;
                    w_rsp_valid_nxt = c_ONE << r_owner;
                    w_state_nxt     = S_RESP;
                end else if (w_timeout) begin
                    w_rsp_data_nxt    = 8'hFF;
                    w_m_start_nxt     = 1'b0;
                    w_rsp_valid_nxt   = c_ONE << r_owner;
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_RESP;
                end
            end
            S_RESP: begin
                w_ptr_nxt   = (r_owner == PTR_W'(NREQ-1)) ? '0 : r_owner + 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_m_start_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_gnt         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= 8'h00;
            r_m_start     <= 1'b0;
            r_m_data_in   <= 8'h00;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_owner       <= w_owner_nxt;
            r_gnt         <= w_gnt_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_m_start     <= w_m_start_nxt;
            r_m_data_in   <= w_m_data_in_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout_err;
    assign m_start     = r_m_start;
    assign m_data_in   = r_m_data_in;

endmodule

`default_nettype wire

// File: tb/tb_spi_rr_arbiter.sv
// ============================================================================
// Module      : tb_spi_rr_arbiter
// Description : Directed self-checking bench for spi_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] tx_data;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        timeout_err;
    logic        m_start;
    logic [7:0]  m_data_in;
    logic [7:0]  m_data_out;
    logic        m_done;

    int n_checks = 0;
    int n_errors = 0;

    // Requester bytes: 0->5A, 1->96, 2->D5, 3->3C
    logic [7:0] tx_exp [4];

    spi_rr_arbiter #(
        .NREQ           (4),
        .PTR_W          (2),
        .TIMEOUT_CYCLES (64)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .tx_data     (tx_data),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .m_start     (m_start),
        .m_data_in   (m_data_in),
        .m_data_out  (m_data_out),
        .m_done      (m_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting from IDLE; lat = edges from grant to m_done sample.
    task automatic xact(input logic [3:0] rq, input logic [3:0] exp_gnt,
                        input logic [7:0] exp_tx, input logic [7:0] rx,
                        input int lat, input bit keep);
        logic [31:0] saved;
        req = rq;
        tick;
        check("gnt", {28'd0, gnt}, {28'd0, exp_gnt});
        check("m_start_on", {31'd0, m_start}, 32'd1);
        check("busy_on", {31'd0, busy}, 32'd1);
        check("m_data_in", {24'd0, m_data_in}, {24'd0, exp_tx});
        saved   = tx_data;
        tx_data = ~tx_data;
        if (!keep) req = 4'b0000;
        repeat (lat - 1) tick;
        check("gnt_pulse", {28'd0, gnt}, 32'd0);
        check("m_start_hold", {31'd0, m_start}, 32'd1);
        m_done     = 1'b1;
        m_data_out = rx;
        tick;
        m_done     = 1'b0;
        m_data_out = 8'h00;
        check("rsp_valid", {28'd0, rsp_valid}, {28'd0, exp_gnt});
        check("rsp_data", {24'd0, rsp_data}, {24'd0, rx});
        check("m_start_off", {31'd0, m_start}, 32'd0);
        check("m_data_in_stable", {24'd0, m_data_in}, {24'd0, exp_tx});
        tx_data = saved;
        tick;
        check("rsp_valid_pulse", {28'd0, rsp_valid}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("rsp_data_hold", {24'd0, rsp_data}, {24'd0, rx});
    endtask

    initial begin
        tx_exp[0] = 8'h5A; tx_exp[1] = 8'h96; tx_exp[2] = 8'hD5; tx_exp[3] = 8'h3C;
        rst        = 1'b1;
        req        = 4'b1111;
        tx_data    = 32'h3CD5_965A;
        m_done     = 1'b0;
        m_data_out = 8'h00;

        tick;
        tick;
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_m_start", {31'd0, m_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("rst_m_data_in", {24'd0, m_data_in}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // First grant after reset goes to requester 0
        xact(4'b1111, 4'b0001, 8'h5A, 8'h11, 3, 1'b0);

        // m_done while idle must not produce a response
        m_done     = 1'b1;
        m_data_out = 8'h77;
        tick;
        m_done     = 1'b0;
        m_data_out = 8'h00;
        check("idle_done_busy", {31'd0, busy}, 32'd0);
        check("idle_done_rsp", {28'd0, rsp_valid}, 32'd0);
        check("idle_done_data", {24'd0, rsp_data}, 32'h11);

        // Single request from requester 2, done 9 cycles later
        xact(4'b0100, 4'b0100, 8'hD5, 8'hAA, 9, 1'b0);
        // Requester 3 leaves pointer at 0
        xact(4'b1000, 4'b1000, 8'h3C, 8'h33, 2, 1'b0);

        // Fairness with all requests held
        for (int i = 0; i < 8; i++) begin
            xact(4'b1111, 4'(1 << (i % 4)), tx_exp[i % 4], 8'(8'h40 + i), 2 + i, 1'b1);
        end

        // Wrap and skip: after grant to 3, 0101 gives 0 then 2
        xact(4'b0101, 4'b0001, 8'h5A, 8'h61, 4, 1'b0);
        xact(4'b0101, 4'b0100, 8'hD5, 8'h62, 4, 1'b0);

        // Reset in third XFER cycle, coincident with m_done
        req = 4'b0010;
        tick;
        check("mid_gnt", {28'd0, gnt}, 32'b0010);
        req = 4'b0000;
        tick;
        tick;
        rst        = 1'b1;
        m_done     = 1'b1;
        m_data_out = 8'hEE;
        tick;
        rst        = 1'b0;
        m_done     = 1'b0;
        m_data_out = 8'h00;
        check("mid_rst_m_start", {31'd0, m_start}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("mid_rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        tick;
        check("mid_rst_no_rsp", {28'd0, rsp_valid}, 32'd0);
        // Pointer back at 0
        xact(4'b1111, 4'b0001, 8'h5A, 8'h5C, 3, 1'b0);

        // No m_done at all; pointer now 1, only requester 0 asks
        req = 4'b0001;
        tick;
        check("to_gnt", {28'd0, gnt}, 32'b0001);
        req = 4'b0000;
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (63) tick;
        check("to_m_start_64", {31'd0, m_start}, 32'd1);
        check("to_err_early", {31'd0, timeout_err}, 32'd0);
        tick;
        check("to_m_start_off", {31'd0, m_start}, 32'd0);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_rsp_valid", {28'd0, rsp_valid}, 32'b0001);
        check("to_rsp_data", {24'd0, rsp_data}, 32'hFF);
        tick;
        check("to_err_pulse", {31'd0, timeout_err}, 32'd0);
        check("to_rsp_pulse", {28'd0, rsp_valid}, 32'd0);
        check("to_busy_idle", {31'd0, busy}, 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick;
            check("busy_stuck", {31'd0, busy}, 32'd1);
        end
        check("no_to_err", {31'd0, timeout_err}, 32'd0);
        check("no_to_m_start", {31'd0, m_start}, 32'd1);
        check("no_to_rsp", {28'd0, rsp_valid}, 32'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("no_to_rst_busy", {31'd0, busy}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
